// File: rtl/ifetch_queue_if.sv
// Bus bundle for ifetch_queue: instruction-memory fetch port plus the
// control-unit side (pop / redirect in, head entry and occupancy out).
// master: the prefetch queue itself. slave: memory + control unit.
interface ifetch_queue_if #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] im_addr;
   logic [DATA_W-1:0] im_data;
   logic              pop;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_addr;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              valid;
   logic [CNT_W-1:0]  count;

   modport master (
      output im_addr, instr, instr_pc, valid, count,
      input  im_data, pop, redirect, redirect_addr
   );

   modport slave (
      input  im_addr, instr, instr_pc, valid, count,
      output im_data, pop, redirect, redirect_addr
   );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue. Drives fetch_pc into a combinational
// instruction memory, stores {word, address} in a DEPTH-entry FIFO and
// presents the head entry to the instruction register. A redirect flushes
// the queue and restarts fetch at redirect_addr.
// Optional feature: define IFQ_HALT_STOP_EN to stop fetching after a word
// whose top nibble is 4'hF (HLT) has been queued.
module ifetch_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic            clk,
   input  logic            rst_f,
   ifetch_queue_if.master  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] pc;
   } entry_t;

   entry_t            mem_q [DEPTH];
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              valid;
   logic              pop_eff;
   logic              push;
   logic              halted;

`ifdef IFQ_HALT_STOP_EN
   typedef enum logic {FETCH, HALTED} state_e;
   state_e state_q, state_d;
   logic   hlt_word;

   assign hlt_word = (bus.im_data[DATA_W-1 -: 4] == 4'hF);

   // Halt state register; redirect and reset return to FETCH.
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) state_q <= FETCH;
      else        state_q <= state_d;
   end

   // Next state: enter HALTED on the edge an HLT word is queued.
   always_comb begin
      state_d = state_q;
      if (bus.redirect)          state_d = FETCH;
      else if (push && hlt_word) state_d = HALTED;
   end

   // State decode: fetching is blocked only while HALTED.
   always_comb begin
      halted = (state_q == HALTED);
   end
`else
   assign halted = 1'b0;
`endif

   assign valid   = (count_q != '0);
   // A pop on an empty queue, or in a redirect cycle, is simply dropped.
   assign pop_eff = bus.pop && valid && !bus.redirect;
   // Full queue still accepts a push when the head leaves on the same edge.
   assign push    = !bus.redirect && !halted && ((count_q != FULL_CNT) || pop_eff);

   // Pointer, occupancy and fetch-address update; redirect overrides all.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      fetch_pc_d = fetch_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (bus.redirect) begin
         fetch_pc_d = bus.redirect_addr;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
         end
         if (pop_eff) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push && !pop_eff)      count_d = count_q + CNT_W'(1);
         else if (pop_eff && !push) count_d = count_q - CNT_W'(1);
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_f) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      if (!rst_f) begin
         fetch_pc_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Entry storage: capture the fetched word with its address on push.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; stale entries are never visible because outputs are gated by valid.
      if (push) mem_q[wr_ptr_q] <= '{data: bus.im_data, pc: fetch_pc_q};
   end

   assign bus.im_addr  = fetch_pc_q;
   assign bus.valid    = valid;
   assign bus.count    = count_q;
   assign bus.instr    = valid ? mem_q[rd_ptr_q].data : '0;
   assign bus.instr_pc = valid ? mem_q[rd_ptr_q].pc   : '0;
endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed vector table, hand-written
// corner sequences (pop on empty, async reset, HLT handling) and a random
// run compared against a queue-based reference model.
module tb_ifetch_queue;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic rst_f;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic              hlt_en   = 1'b0;
   logic [ADDR_W-1:0] hlt_addr = '0;

   ifetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   ifetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_f (rst_f),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Instruction memory contents as a function of address.
   function automatic logic [DATA_W-1:0] word_at(input logic [ADDR_W-1:0] a,
                                                 input logic en,
                                                 input logic [ADDR_W-1:0] ha);
      if (en && a == ha) return 32'hF000_0000;
      return 32'h1000_0000 + {16'h0, a};
   endfunction

   always_comb bus.im_data = word_at(bus.im_addr, hlt_en, hlt_addr);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [ADDR_W-1:0] mq[$];
   logic [ADDR_W-1:0] m_pc;
   bit                m_halted;

   function automatic void model_reset();
      mq.delete();
      m_pc     = '0;
      m_halted = 1'b0;
   endfunction

   function automatic void model_step(input bit p, input bit r, input logic [ADDR_W-1:0] ra);
      bit pe, ps;
      logic [DATA_W-1:0] w;
      if (r) begin
         mq.delete();
         m_pc     = ra;
         m_halted = 1'b0;
         return;
      end
      pe = p && (mq.size() > 0);
      ps = !m_halted && ((mq.size() < DEPTH) || pe);
      if (pe) void'(mq.pop_front());
      if (ps) begin
         mq.push_back(m_pc);
         w = word_at(m_pc, hlt_en, hlt_addr);
`ifdef IFQ_HALT_STOP_EN
         if (w[31:28] == 4'hF) m_halted = 1'b1;
`endif
         m_pc = m_pc + 16'd1;
      end
   endfunction

   task automatic check_model(input string tag);
      logic [ADDR_W-1:0] hp;
      hp = (mq.size() > 0) ? mq[0] : '0;
      check({tag, ".valid"},    bus.valid, mq.size() > 0);
      check({tag, ".count"},    bus.count, mq.size());
      check({tag, ".instr_pc"}, bus.instr_pc, hp);
      check({tag, ".instr"},    bus.instr,
            (mq.size() > 0) ? word_at(hp, hlt_en, hlt_addr) : 32'h0);
      check({tag, ".im_addr"},  bus.im_addr, m_pc);
   endtask

   // Advance one clock edge and sample 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.pop           = 1'b0;
      bus.redirect      = 1'b0;
      bus.redirect_addr = '0;
      rst_f = 1'b0;
      #12;
      check("rst.valid",    bus.valid, 1'b0);
      check("rst.count",    bus.count, 0);
      check("rst.instr",    bus.instr, 0);
      check("rst.instr_pc", bus.instr_pc, 0);
      check("rst.im_addr",  bus.im_addr, 0);
      @(negedge clk);
      rst_f = 1'b1;
      model_reset();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic              pop;
      logic              redirect;
      logic [ADDR_W-1:0] raddr;
      logic              exp_valid;
      int                exp_count;
      logic [ADDR_W-1:0] exp_pc;
      logic [ADDR_W-1:0] exp_im;
   } vec_t;

   vec_t vecs[16];

   initial begin
      logic [DATA_W-1:0] exp_instr;
      bit p, r;
      logic [ADDR_W-1:0] ra;

      //           pop   red   raddr     vld  cnt pc        im_addr
      vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1, 16'h0000, 16'h0001};
      vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 2, 16'h0000, 16'h0002};
      vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 3, 16'h0000, 16'h0003};
      vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 4, 16'h0000, 16'h0004};
      vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 4, 16'h0000, 16'h0004};
      vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 4, 16'h0001, 16'h0005};
      vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 4, 16'h0002, 16'h0006};
      vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 4, 16'h0003, 16'h0007};
      vecs[8]  = '{1'b1, 1'b1, 16'h0040, 1'b0, 0, 16'h0000, 16'h0040};
      vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1, 16'h0040, 16'h0041};
      vecs[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1, 16'h0041, 16'h0042};
      vecs[11] = '{1'b0, 1'b1, 16'hFFFE, 1'b0, 0, 16'h0000, 16'hFFFE};
      vecs[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1, 16'hFFFE, 16'hFFFF};
      vecs[13] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1, 16'hFFFF, 16'h0000};
      vecs[14] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1, 16'h0000, 16'h0001};
      vecs[15] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1, 16'h0001, 16'h0002};

      do_reset();
      for (int i = 0; i < 16; i++) begin
         bus.pop           = vecs[i].pop;
         bus.redirect      = vecs[i].redirect;
         bus.redirect_addr = vecs[i].raddr;
         step();
         exp_instr = vecs[i].exp_valid ? (32'h1000_0000 + {16'h0, vecs[i].exp_pc}) : 32'h0;
         check($sformatf("vec%0d.valid", i),    bus.valid,    vecs[i].exp_valid);
         check($sformatf("vec%0d.count", i),    bus.count,    vecs[i].exp_count);
         check($sformatf("vec%0d.instr_pc", i), bus.instr_pc, vecs[i].exp_pc);
         check($sformatf("vec%0d.instr", i),    bus.instr,    exp_instr);
         check($sformatf("vec%0d.im_addr", i),  bus.im_addr,  vecs[i].exp_im);
      end

      // Pop on empty right after reset: ignored, the push still lands.
      do_reset();
      bus.pop = 1'b1;
      #1;
      check("empty_pop.pre_count", bus.count, 0);
      check("empty_pop.pre_instr", bus.instr, 0);
      step();
      check("empty_pop.count",    bus.count, 1);
      check("empty_pop.instr_pc", bus.instr_pc, 0);
      check("empty_pop.instr",    bus.instr, 32'h1000_0000);
      bus.pop = 1'b0;

      // Asynchronous reset mid-operation clears immediately, between edges.
      step();
      step();
      #2;
      rst_f = 1'b0;
      #1;
      check("async_rst.count",   bus.count, 0);
      check("async_rst.valid",   bus.valid, 1'b0);
      check("async_rst.instr",   bus.instr, 0);
      check("async_rst.im_addr", bus.im_addr, 0);
      @(negedge clk);
      rst_f = 1'b1;
      step();
      check("after_rst.instr_pc", bus.instr_pc, 0);
      check("after_rst.count",    bus.count, 1);

      // HLT word at address 2.
      hlt_en   = 1'b1;
      hlt_addr = 16'h0002;
      do_reset();
      for (int i = 0; i < 6; i++) step();
`ifdef IFQ_HALT_STOP_EN
      check("hlt.count_sat", bus.count, 3);
      check("hlt.im_hold",   bus.im_addr, 3);
`else
      check("hlt.count_sat", bus.count, 4);
      check("hlt.im_hold",   bus.im_addr, 4);
`endif
      bus.pop = 1'b1;
      step();
      step();
      bus.pop = 1'b0;
      check("hlt.head_instr", bus.instr, 32'hF000_0000);
      check("hlt.head_pc",    bus.instr_pc, 2);
`ifdef IFQ_HALT_STOP_EN
      check("hlt.count_after_pop", bus.count, 1);
      check("hlt.im_after_pop",    bus.im_addr, 3);
`else
      check("hlt.count_after_pop", bus.count, 4);
      check("hlt.im_after_pop",    bus.im_addr, 6);
`endif
      bus.redirect      = 1'b1;
      bus.redirect_addr = 16'h0010;
      step();
      bus.redirect = 1'b0;
      check("hlt.redir_valid", bus.valid, 1'b0);
      step();
      check("hlt.resume_pc",    bus.instr_pc, 16'h0010);
      check("hlt.resume_count", bus.count, 1);
      check("hlt.resume_im",    bus.im_addr, 16'h0011);

      // Random traffic against the reference model.
      hlt_en = 1'b0;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         p  = ($urandom % 4) != 0;
         r  = ($urandom % 32) == 0;
         ra = (($urandom % 4) == 0) ? 16'hFFFC + 16'($urandom % 4) : 16'($urandom);
         bus.pop           = p;
         bus.redirect      = r;
         bus.redirect_addr = ra;
         model_step(p, r, ra);
         step();
         check_model($sformatf("rnd%0d", c));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Instruction prefetch buffer between instruction memory and the instruction register. It drives the fetch address into the combinational instruction memory and stores each returned word, tagged with its address, in a small FIFO. The control unit pops one entry per instruction load and redirects the queue on a taken branch or reset vector.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
ADDR_W, 16, instruction address width (word addressed)
DATA_W, 32, instruction width

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst_f  input  1  asynchronous active-low reset
im_addr  output  ADDR_W  fetch address to instruction memory
im_data  input  DATA_W  instruction memory read data; combinational from im_addr
pop  input  1  consume head entry; asserted with the instruction-load strobe
redirect  input  1  flush the queue and restart fetch
redirect_addr  input  ADDR_W  new fetch address on redirect
instr  output  DATA_W  head instruction; 0 when empty
instr_pc  output  ADDR_W  address of head instruction; 0 when empty
valid  output  1  queue non-empty
count  output  log2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst_f low, asynchronous): fetch_pc=0, rd/wr pointers=0, count=0, halted=0. Outputs: valid=0, instr=0, instr_pc=0, im_addr=0.
- im_addr = fetch_pc, driven combinationally from the register.
- Push condition: !redirect && !halted && (count<DEPTH || pop_eff).
  - On push, write {im_data, fetch_pc} at wr_ptr, advance wr_ptr, fetch_pc <= fetch_pc+1.
  - fetch_pc wraps modulo 2^ADDR_W (FFFF -> 0000), and the pointers wrap modulo DEPTH.
- pop_eff = pop && valid && !redirect.
  - Pop while empty is ignored; it does not change state and does not flag an error.
- count update: count+1 on push only, count-1 on pop_eff only, unchanged when both occur. When full, a push and a pop in the same cycle are both accepted.
- Latency: a word fetched at edge N is visible on instr/valid after edge N, so there is a 1-cycle fill latency after reset or redirect. At steady state the queue sustains 1 instruction per cycle.
- Redirect has the highest priority. On the edge where redirect=1:
  - count=0, pointers=0, fetch_pc <= redirect_addr, halted=0.
  - No push and no pop occur that cycle.
  - valid=0 on the following cycle.
- Output mux: instr/instr_pc show the head entry when valid=1, and forced zero otherwise. They change only at clock edges or on asynchronous reset.
- Reset mid-operation discards all entries immediately; fetch resumes at address 0 after rst_f deasserts.
- There is no internal state machine beyond the halted flag (states FETCH/HALTED); the HALTED state exists only with the optional feature.

Optional Feature:
Macro IFQ_HALT_STOP_EN.
- Defined: when a word with im_data[31:28]==4'hF (HLT) is pushed, halted <= 1 on the same edge.
  - While halted, no further pushes occur and fetch_pc holds at HLT address + 1.
  - Queued entries still pop normally.
  - redirect or reset clears halted.
- Not defined: halted is tied to 0 and fetch streams past HLT continuously.

Test Plan:
- Reset then release; im returns 32'h1000_0000 + addr; pop=0 -> after 4 edges count=4, valid=1, instr=32'h1000_0000, instr_pc=0, and im_addr holds 4.
- Full queue, pop=1 for 3 cycles -> count stays 4; instr_pc steps 1, 2, 3; im_addr steps 5, 6, 7.
- Redirect with redirect_addr=16'h0040 and pop=1 in the same cycle -> next cycle valid=0, count=0; the cycle after that, instr_pc=0x0040 and count=1.
- Redirect to 16'hFFFE, pop continuous -> instr_pc sequence FFFE, FFFF, 0000, 0001; no entry is lost or duplicated.
- Pop on empty immediately after reset -> count stays 0 and instr=0; the next push yields count=1 and instr_pc=0.
- With IFQ_HALT_STOP_EN: word at 16'h0002 is 32'hF000_0000 -> count saturates at 3, im_addr holds 3; a later redirect to 16'h0010 resumes fetch from 0x0010.
